apb_mem_completer: RTL and testbench
====================================

Name: apb_mem_completer

Overview:
- APB (AMBA 3/4) completer exposing a word-addressed RAM. It is the responder end of the bus the multicycle RISC-V core drives for its MEMREAD/MEMWRITE states, via the APB requester bridge.
- Supports programmable wait states, byte strobes, and an error response for misaligned or out-of-range addresses.
- Sits on the APB bus as the system data/instruction memory.

Parameters:
- ADDR_W, 32, width of paddr.
- DATA_W, 32, data width; pstrb width is DATA_W/8.
- DEPTH, 256, number of DATA_W words; must be a power of 2. Valid byte range is 0 .. DEPTH*4-1.
- WAIT_CYCLES, 0, number of access cycles with pready low before pready goes high; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- psel  in  1  completer select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte write strobes; ignored on reads.
- prdata  out  DATA_W  read data; valid only while pready=1.
- pready  out  1  transfer completes on a cycle with pready=1.
- pslverr  out  1  error response; valid only while pready=1.

Behaviour:
- States: IDLE, WAIT, RESP. Outputs are decoded from registered state and registered data only; no combinational path from inputs to outputs.
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, captured request cleared. Outputs: pready=0, pslverr=0, prdata=0. RAM contents are not cleared and persist across reset.
- pready = (state==RESP). pslverr = (state==RESP) & err_q. prdata = rdata_q.
- Setup detect, evaluated in IDLE or RESP: psel=1 & penable=0.
  - Capture paddr, pwrite, pwdata, pstrb.
  - err = (paddr[1:0]!=0) | (paddr >= DEPTH*4).
  - If WAIT_CYCLES==0: go to RESP. Otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
- WAIT: if psel=0 (requester abort), go to IDLE with no side effect. Else if cnt==0, go to RESP. Else decrement cnt.
- Timing: setup in cycle T gives pready=1 in cycle T+1+WAIT_CYCLES.
- On the edge entering RESP: rdata_q = (read & !err) ? mem[paddr[log2(DEPTH)+1:2]] : 0.
- RESP, write commit: on the edge ending RESP, if psel=1 & penable=1 & pwrite=1 & !err, byte i of the word is written when pstrb[i]=1. Other bytes are unchanged; pstrb=0 writes nothing. No write on error.
- RESP exit: if a setup is detected, start the new transfer as above (back-to-back, no idle cycle). Otherwise go to IDLE.
- Protocol violation: psel=1 & penable=1 seen in IDLE (access without setup). Go to RESP with err_q=1, giving a one-cycle-later error response. No RAM access.
- psel dropped in RESP: go to IDLE, no write.
- paddr/pwrite changes during the access phase are ignored; the values captured at setup govern the transfer.
- Reset asserted mid-transfer: immediate return to IDLE, pending write discarded, outputs at reset values.
- Read-after-write to the same word in back-to-back transfers returns the new data, because the write commits before the next RESP entry.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x10 with pstrb=4'hF, then read 0x10. Required: pready=1 in the first access cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- WAIT_CYCLES=3: read 0x10. Required: pready low for 3 access cycles, high on the 4th; prdata=0xDEADBEEF.
- Strobes: write 0x11223344 to 0x10 with pstrb=4'b0101, then read 0x10. Required: prdata=0xDE22BE44.
- Errors: write to 0x12 (misaligned), then to 0x400 (DEPTH=256, out of range). Required: pslverr=1 with pready=1 on both. Then read 0x10: required prdata unchanged (0xDE22BE44) and pslverr=0.
- Back-to-back with no idle: write 0xA5A5A5A5 to 0x20, then an immediate setup reading 0x20. Required: prdata=0xA5A5A5A5. Separately, penable=1 without a setup cycle: required pready=1 with pslverr=1 one cycle later.
- Abort and reset: WAIT_CYCLES=3, drop psel during WAIT; required return to IDLE, no write (read-back shows old data). Separately, assert reset during a write's WAIT; required pready=pslverr=0, prdata=0 immediately, and the target word unchanged afterwards.

Source files
------------

// File: rtl/apb_mem_completer.sv
// APB completer fronting a word-addressed RAM with byte strobes, programmable
// wait states and an error response for misaligned/out-of-range/unsetup accesses.
module apb_mem_completer #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LIMIT    = (ADDR_W + 1)'(DEPTH * 4);
   localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                setup;
   logic                start;
   logic                mem_we;
   logic [IDX_W-1:0]    req_idx;
   logic                req_err;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      start   = 1'b0;

      setup   = psel & ~penable;
      req_idx = paddr[IDX_W+1:2];
      req_err = (paddr[1:0] != 2'b00) | ({1'b0, paddr} >= LIMIT);

      case (state_q)
         IDLE: begin
            if (setup) begin
               start = 1'b1;
            end else if (psel && penable) begin
               state_d = RESP;
               err_d   = 1'b1;
               write_d = 1'b0;
               rdata_d = '0;
            end
         end
         WAIT: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
               rdata_d = (!write_q && !err_q) ? mem[idx_q] : '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            mem_we = psel & penable & write_q & ~err_q;
            if (setup) begin
               start = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Zero wait states read the RAM straight from the setup-phase bus.
      if (start) begin
         idx_d   = req_idx;
         write_d = pwrite;
         wdata_d = pwdata;
         strb_d  = pstrb;
         err_d   = req_err;
         if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            rdata_d = (!pwrite && !req_err) ? mem[req_idx] : '0;
         end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM is deliberately not reset so contents survive a bus reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < STRB_W; i++) begin
            if (strb_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
         end
      end
   end

   assign pready  = (state_q == RESP);
   assign pslverr = (state_q == RESP) & err_q;
   assign prdata  = rdata_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Directed bench for apb_mem_completer: one zero-wait and one three-wait instance
// share the bus; sel3 routes psel to one of them.
module tb_apb_mem_completer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        sel3 = 1'b0;

   logic        psel_0, psel_3;
   logic [31:0] prdata_0, prdata_3, prdata;
   logic        pready_0, pready_3, pready;
   logic        pslverr_0, pslverr_3, pslverr;

   int total = 0;
   int bad   = 0;

   assign psel_0  = psel & ~sel3;
   assign psel_3  = psel & sel3;
   assign pready  = sel3 ? pready_3  : pready_0;
   assign pslverr = sel3 ? pslverr_3 : pslverr_0;
   assign prdata  = sel3 ? prdata_3  : prdata_0;

   always #5 clk = ~clk;

   apb_mem_completer #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .psel(psel_0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata_0), .pready(pready_0), .pslverr(pslverr_0)
   );

   apb_mem_completer #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .psel(psel_3), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata_3), .pready(pready_3), .pslverr(pslverr_3)
   );

   // Leaves the bus in the access phase on return so a following call is back-to-back.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er,
                       output int waits);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0;
      while (!pready && waits < 20) begin
         waits++;
         @(posedge clk); #1;
      end
      rd = prdata;
      er = pslverr;
   endtask

   task automatic bus_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         psel = 1'b0; penable = 1'b0;
      end
   endtask

   task automatic test_reset;
      #1;
      total++; if (pready_0 !== 1'b0) begin bad++; $display("FAIL reset_pready0 got=%b exp=0", pready_0); end
      total++; if (pslverr_0 !== 1'b0) begin bad++; $display("FAIL reset_pslverr0 got=%b exp=0", pslverr_0); end
      total++; if (prdata_0 !== 32'h0) begin bad++; $display("FAIL reset_prdata0 got=%h exp=0", prdata_0); end
      total++; if (pready_3 !== 1'b0) begin bad++; $display("FAIL reset_pready3 got=%b exp=0", pready_3); end
      total++; if (prdata_3 !== 32'h0) begin bad++; $display("FAIL reset_prdata3 got=%h exp=0", prdata_3); end
      @(negedge clk); reset = 1'b1;
      bus_idle(2);
   endtask

   task automatic test_zero_wait;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b0;
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, w);
      total++; if (w !== 0) begin bad++; $display("FAIL w0_write_waits got=%0d exp=0", w); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL w0_write_err got=%b exp=0", er); end
      bus_idle(1);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
      total++; if (w !== 0) begin bad++; $display("FAIL w0_read_waits got=%0d exp=0", w); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL w0_read_data got=%h exp=deadbeef", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL w0_read_err got=%b exp=0", er); end
      bus_idle(1);
   endtask

   task automatic test_wait_states;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b1;
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, w);
      total++; if (w !== 3) begin bad++; $display("FAIL w3_write_waits got=%0d exp=3", w); end
      bus_idle(1);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
      total++; if (w !== 3) begin bad++; $display("FAIL w3_read_waits got=%0d exp=3", w); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL w3_read_data got=%h exp=deadbeef", rd); end
      bus_idle(1);
      sel3 = 1'b0;
   endtask

   task automatic test_strobes;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b0;
      xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, w);
      bus_idle(1);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
      total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL strobe_data got=%h exp=de22be44", rd); end
      bus_idle(1);
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b0;
      xfer(1'b1, 32'h12, 32'h55555555, 4'hF, rd, er, w);
      total++; if (er !== 1'b1 || w !== 0) begin bad++; $display("FAIL err_misaligned got=err%b/w%0d exp=err1/w0", er, w); end
      bus_idle(1);
      xfer(1'b1, 32'h400, 32'h66666666, 4'hF, rd, er, w);
      total++; if (er !== 1'b1 || w !== 0) begin bad++; $display("FAIL err_range got=err%b/w%0d exp=err1/w0", er, w); end
      bus_idle(1);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
      total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL err_readback got=%h exp=de22be44", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL err_readback_err got=%b exp=0", er); end
      bus_idle(1);
      xfer(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, w);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL err_last_word got=%b exp=0", er); end
      bus_idle(1);
      xfer(1'b0, 32'h400, 32'h0, 4'h0, rd, er, w);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_read_range got=err%b/%h exp=err1/0", er, rd); end
      bus_idle(1);
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b0;
      xfer(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, rd, er, w);
      xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, er, w);
      total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL b2b_data got=%h exp=a5a5a5a5", rd); end
      total++; if (w !== 0 || er !== 1'b0) begin bad++; $display("FAIL b2b_resp got=w%0d/err%b exp=w0/err0", w, er); end
      bus_idle(1);
   endtask

   task automatic test_no_setup;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b0;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL nosetup_early got=%b exp=0", pready); end
      @(posedge clk); #1;
      total++; if (pready !== 1'b1 || pslverr !== 1'b1) begin bad++; $display("FAIL nosetup_err got=rdy%b/err%b exp=1/1", pready, pslverr); end
      psel = 1'b0; penable = 1'b0;
      bus_idle(1);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
      total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL nosetup_nowrite got=%h exp=de22be44", rd); end
      bus_idle(1);
   endtask

   task automatic test_abort;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b1;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h12345678; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL abort_wait got=%b exp=0", pready); end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", pready); end
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
      total++; if (rd !== 32'hDEADBEEF || w !== 3) begin bad++; $display("FAIL abort_nowrite got=%h/w%0d exp=deadbeef/w3", rd, w); end
      bus_idle(1);
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd; logic er; int w;
      sel3 = 1'b1;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      total++; if (prdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rstmid_pre got=%h exp=deadbeef", prdata); end
      #2 reset = 1'b0;
      #1;
      total++; if (pready !== 1'b0 || pslverr !== 1'b0) begin bad++; $display("FAIL rstmid_ctl got=%b%b exp=00", pready, pslverr); end
      total++; if (prdata !== 32'h0) begin bad++; $display("FAIL rstmid_prdata got=%h exp=0", prdata); end
      psel = 1'b0; penable = 1'b0;
      @(negedge clk); @(negedge clk); reset = 1'b1;
      bus_idle(2);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rstmid_nowrite got=%h exp=deadbeef", rd); end
      bus_idle(1);
   endtask

   initial begin
      test_reset;
      test_zero_wait;
      test_wait_states;
      test_strobes;
      test_errors;
      test_back_to_back;
      test_no_setup;
      test_abort;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
